// File: rtl/conv_tap_feeder.sv
// conv_tap_feeder: 3-tap sliding window feeding one registered signed product per cycle with first/last framing
module conv_tap_feeder #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_load,
  input  logic [1:0]               coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     win_clear,
  output logic                     prod_valid,
  output logic signed [OUT_W-1:0]  prod_data,
  output logic                     prod_first,
  output logic                     prod_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam int P_W = DATA_W + COEF_W;
  state_t state;
  logic [1:0] tap, fill;
  logic signed [DATA_W-1:0] w0, w1, w2, sel_w;
  logic signed [COEF_W-1:0] c0, c1, c2, sel_c;
  logic signed [P_W-1:0] p;
  logic accept;
  assign s_ready = !reset && (state == IDLE || tap == 2'd2);
  assign accept = s_valid && s_ready && !win_clear;
  always_comb begin
    sel_w = tap == 2'd0 ? w0 : tap == 2'd1 ? w1 : w2;
    sel_c = tap == 2'd0 ? c0 : tap == 2'd1 ? c1 : c2;
    p = P_W'(sel_w) * P_W'(sel_c);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tap <= '0;
      fill <= '0;
      {w0, w1, w2} <= '0;
      {c0, c1, c2} <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last <= 1'b0;
      prod_data <= '0;
    end else if (win_clear) begin
      state <= IDLE;
      tap <= '0;
      fill <= '0;
      {w0, w1, w2} <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last <= 1'b0;
    end else begin
      if (coef_load && state == IDLE) begin
        if (coef_idx == 2'd0) c0 <= coef_data;
        if (coef_idx == 2'd1) c1 <= coef_data;
        if (coef_idx == 2'd2) c2 <= coef_data;
      end
      prod_valid <= state == EMIT;
      prod_first <= state == EMIT && tap == 2'd0;
      prod_last <= state == EMIT && tap == 2'd2;
      if (state == EMIT) prod_data <= OUT_W'(p);
      // tap-2 product above reads the pre-shift window at the same edge as the shift
      if (accept) begin
        {w0, w1, w2} <= {w1, w2, s_data};
        fill <= fill == 2'd3 ? 2'd3 : fill + 2'd1;
        state <= fill >= 2'd2 ? EMIT : IDLE;
        tap <= '0;
      end else if (state == EMIT) begin
        state <= tap == 2'd2 ? IDLE : EMIT;
        tap <= tap == 2'd2 ? 2'd0 : tap + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_conv_tap_feeder.sv
// tb_conv_tap_feeder: directed self-checking bench for conv_tap_feeder
module tb_conv_tap_feeder;
  logic clk = 0, reset = 1, coef_load = 0, s_valid = 0, win_clear = 0;
  logic [1:0] coef_idx = 0;
  logic signed [15:0] coef_data = 0, s_data = 0;
  logic s_ready, prod_valid, prod_first, prod_last;
  logic signed [31:0] prod_data;
  int checks = 0, errors = 0;
  conv_tap_feeder dut (
    .clk(clk), .reset(reset), .coef_load(coef_load), .coef_idx(coef_idx),
    .coef_data(coef_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .win_clear(win_clear), .prod_valid(prod_valid), .prod_data(prod_data),
    .prod_first(prod_first), .prod_last(prod_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_coef(input logic [1:0] idx, input logic signed [15:0] val);
    coef_load = 1; coef_idx = idx; coef_data = val;
    tick;
    coef_load = 0;
  endtask
  task automatic send(input logic signed [15:0] val);
    s_valid = 1; s_data = val;
    tick;
    s_valid = 0;
  endtask
  task automatic clear;
    win_clear = 1;
    tick;
    win_clear = 0;
  endtask
  task automatic expect_window(input string tag, input logic [31:0] e0, e1, e2);
    tick;
    chk({tag, "_v0"}, prod_valid, 1); chk({tag, "_f0"}, prod_first, 1);
    chk({tag, "_l0"}, prod_last, 0); chk({tag, "_d0"}, prod_data, e0);
    tick;
    chk({tag, "_v1"}, prod_valid, 1); chk({tag, "_f1"}, prod_first, 0);
    chk({tag, "_l1"}, prod_last, 0); chk({tag, "_d1"}, prod_data, e1);
    tick;
    chk({tag, "_v2"}, prod_valid, 1); chk({tag, "_f2"}, prod_first, 0);
    chk({tag, "_l2"}, prod_last, 1); chk({tag, "_d2"}, prod_data, e2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    tick; tick;
    chk("rst_ready", s_ready, 0); chk("rst_valid", prod_valid, 0);
    chk("rst_data", prod_data, 0); chk("rst_first", prod_first, 0);
    chk("rst_last", prod_last, 0);
    reset = 0;
    #1 chk("rel_ready", s_ready, 1);
    // basic window
    load_coef(0, 1); load_coef(1, 2); load_coef(2, 3);
    send(1); chk("b_nv1", prod_valid, 0);
    tick; chk("b_nv2", prod_valid, 0);
    send(2); chk("b_nv3", prod_valid, 0);
    tick; chk("b_nv4", prod_valid, 0);
    send(3);
    expect_window("b1", 1, 4, 9);
    tick; chk("b_idle", prod_valid, 0); chk("b_hold", prod_data, 9);
    send(4);
    expect_window("b2", 2, 6, 12);
    tick; chk("b_idle2", prod_valid, 0); chk("b_hold2", prod_data, 12);
    // signed extremes
    clear;
    load_coef(0, -16'sd32768); load_coef(1, 16'sd32767); load_coef(2, 0);
    send(-16'sd32768); send(-16'sd32768); send(5);
    expect_window("sx", 32'h40000000, 32'hC0008000, 32'h00000000);
    tick;
    // streaming
    load_coef(0, 1); load_coef(1, 1); load_coef(2, 1);
    clear;
    begin
      int nx = 1;
      for (int c = 0; c < 18; c++) begin
        if (c <= 14) chk($sformatf("st_rdy%0d", c), s_ready, (c < 3 || c % 3 == 2) ? 1 : 0);
        chk($sformatf("st_v%0d", c), prod_valid, (c >= 4 && c <= 15) ? 1 : 0);
        if (c >= 4 && c <= 15) begin
          chk($sformatf("st_d%0d", c), prod_data, (c - 4) / 3 + (c - 4) % 3 + 1);
          chk($sformatf("st_f%0d", c), prod_first, (c - 4) % 3 == 0 ? 1 : 0);
          chk($sformatf("st_l%0d", c), prod_last, (c - 4) % 3 == 2 ? 1 : 0);
        end
        s_valid = nx <= 6; s_data = 16'(nx);
        begin
          logic acc;
          acc = s_valid && s_ready;
          tick;
          if (acc) nx++;
        end
      end
      s_valid = 0;
    end
    // coefficient gating: window now (4,5,6)
    send(10);
    coef_load = 1; coef_idx = 0; coef_data = 7;
    expect_window("cg1", 5, 6, 10);
    coef_load = 0;
    send(11);
    expect_window("cg2", 6, 10, 11);
    load_coef(0, 7);
    send(12);
    expect_window("cg3", 70, 11, 12);
    load_coef(3, 99);
    send(13);
    expect_window("cg4", 77, 12, 13);
    // clear mid-window at tap 1
    send(14);
    tick;
    chk("cl_v0", prod_valid, 1); chk("cl_d0", prod_data, 84);
    win_clear = 1; s_valid = 1; s_data = 99;
    tick;
    win_clear = 0; s_valid = 0;
    chk("cl_v1", prod_valid, 0); chk("cl_l1", prod_last, 0);
    tick;
    chk("cl_v2", prod_valid, 0); chk("cl_l2", prod_last, 0);
    send(1); send(2);
    tick; chk("cl_nv1", prod_valid, 0);
    tick; chk("cl_nv2", prod_valid, 0);
    send(3);
    expect_window("cl", 7, 2, 3);
    // reset mid-EMIT
    send(4);
    tick;
    chk("rs_v0", prod_valid, 1);
    reset = 1;
    #1 chk("rs_rdy_hi", s_ready, 0);
    tick;
    chk("rs_v", prod_valid, 0); chk("rs_d", prod_data, 0);
    chk("rs_f", prod_first, 0); chk("rs_l", prod_last, 0);
    chk("rs_rdy", s_ready, 0);
    reset = 0;
    #1 chk("rs_rdy_rel", s_ready, 1);
    send(5); send(6); send(7);
    expect_window("rs", 0, 0, 0);
    tick;
    chk("rs_end", prod_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
